// File: rtl/pe_decoder.sv
// Index-to-vector decoder: registered one-hot pulse on Q per accepted idx, then an idle gap.
// Build option PE_DECODER_THERMO_EN drives a thermometer mask [idx:0] instead of one-hot.
// state | meaning
// IDLE  | in_ready high, waiting for an idx handshake
// HOLD  | Q driven non-zero, cnt counts remaining pulse cycles
// GAP   | Q forced to zero, cnt counts remaining idle cycles
module pe_decoder #(
  parameter int N         = 8,
  parameter int IDX_W     = $clog2(N),
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     Q,
  output logic             q_valid,
  output logic             err,
  output logic [7:0]       acc_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [N-1:0]   q_q, q_d;
  logic           q_valid_q, q_valid_d;
  logic           err_q, err_d;
  logic [7:0]     acc_cnt_q, acc_cnt_d;
  logic           in_ready_q, in_ready_d;
  logic [N-1:0]   q_dec;
  logic           idx_in_range;

  assign idx_in_range = int'(idx) < N;

  always_comb begin
    q_dec = '0;
    for (int i = 0; i < N; i++) begin
`ifdef PE_DECODER_THERMO_EN
      q_dec[i] = (i <= int'(idx));
`else
      q_dec[i] = (i == int'(idx));
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    err_d     = 1'b0;
    acc_cnt_d = acc_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (idx_in_range) begin
            q_d       = q_dec;
            q_valid_d = 1'b1;
            cnt_d     = 8'(PULSE_LEN - 1);
            acc_cnt_d = acc_cnt_q + 8'd1;
            state_d   = HOLD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          q_d       = '0;
          q_valid_d = 1'b0;
          if (GAP_LEN > 0) begin
            cnt_d   = 8'(GAP_LEN - 1);
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        q_d       = '0;
        q_valid_d = 1'b0;
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        q_d       = '0;
        q_valid_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
    // in_ready is registered, so it follows the state we are about to enter
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      acc_cnt_q  <= 8'd0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      err_q      <= err_d;
      acc_cnt_q  <= acc_cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign Q        = q_q;
  assign q_valid  = q_valid_q;
  assign err      = err_q;
  assign acc_cnt  = acc_cnt_q;

endmodule

// File: tb/tb_pe_decoder.sv
// Directed bench for pe_decoder: an N=8 instance for timing/wrap/thermometer and
// an N=6 instance for the out-of-range error path.
module tb_pe_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] idx;
  logic [7:0] q;
  logic       q_valid;
  logic       err;
  logic [7:0] acc_cnt;

  logic       in_valid6;
  logic       in_ready6;
  logic [2:0] idx6;
  logic [5:0] q6;
  logic       q_valid6;
  logic       err6;
  logic [7:0] acc_cnt6;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_decoder #(.N(8), .PULSE_LEN(3), .GAP_LEN(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .idx(idx),
    .Q(q), .q_valid(q_valid), .err(err), .acc_cnt(acc_cnt)
  );

  pe_decoder #(.N(6), .PULSE_LEN(3), .GAP_LEN(2)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6), .idx(idx6),
    .Q(q6), .q_valid(q_valid6), .err(err6), .acc_cnt(acc_cnt6)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int penc(input logic [7:0] v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_q;
    logic [7:0] exp_thermo;
    rst = 1'b1; in_valid = 1'b0; idx = '0; in_valid6 = 1'b0; idx6 = '0;
    tick();
    tick();
    chk("rst_q", q, 8'h00);
    chk("rst_qv", q_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_acc", acc_cnt, 8'd0);
    chk("rst_rdy", in_ready, 1'b1);
    rst = 1'b0;
    tick();
    chk("idle_rdy", in_ready, 1'b1);
    chk("idle_q", q, 8'h00);

    // single decode idx=6
    in_valid = 1'b1; idx = 3'd6;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("sd_q", q, 8'h40);
      chk("sd_qv", q_valid, 1'b1);
      chk("sd_rdy", in_ready, 1'b0);
      tick();
    end
    for (int k = 4; k <= 5; k++) begin
      chk("sd_gap_q", q, 8'h00);
      chk("sd_gap_qv", q_valid, 1'b0);
      chk("sd_gap_rdy", in_ready, 1'b0);
      tick();
    end
    chk("sd_rdy_back", in_ready, 1'b1);
    chk("sd_acc", acc_cnt, 8'd1);

    // backpressure: in_valid held high, idx 0 then 7
    in_valid = 1'b1; idx = 3'd0;
    tick();
    idx = 3'd7;
    for (int c = 1; c <= 12; c++) begin
      exp_q = (c >= 1 && c <= 3) ? 8'h01 : (c >= 7 && c <= 9) ? 8'h80 : 8'h00;
      chk("bp_q", q, exp_q);
      chk("bp_rdy", in_ready, (c == 6 || c == 12) ? 1'b1 : 1'b0);
      if (c == 6) chk("bp_acc_mid", acc_cnt, 8'd2);
      if (c < 12) tick();
    end
    in_valid = 1'b0;
    chk("bp_acc", acc_cnt, 8'd3);

    // out-of-range on N=6
    in_valid6 = 1'b1; idx6 = 3'd7;
    tick();
    in_valid6 = 1'b0;
    chk("oor_err", err6, 1'b1);
    chk("oor_q", q6, 6'h00);
    chk("oor_qv", q_valid6, 1'b0);
    chk("oor_acc", acc_cnt6, 8'd0);
    chk("oor_rdy", in_ready6, 1'b1);
    tick();
    chk("oor_err_clr", err6, 1'b0);
    in_valid6 = 1'b1; idx6 = 3'd5;
    tick();
    in_valid6 = 1'b0;
    chk("n6_q", q6, 6'h20);
    chk("n6_err", err6, 1'b0);
    chk("n6_acc", acc_cnt6, 8'd1);

    // reset in second HOLD cycle of idx=3
    in_valid = 1'b1; idx = 3'd3;
    tick();
    in_valid = 1'b0;
    chk("mr_q1", q, 8'h08);
    tick();
    chk("mr_q2", q, 8'h08);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_q", q, 8'h00);
    chk("mr_qv", q_valid, 1'b0);
    chk("mr_acc", acc_cnt, 8'd0);
    chk("mr_rdy", in_ready, 1'b1);
    tick();
    chk("mr_idle_q", q, 8'h00);
    chk("mr_idle_rdy", in_ready, 1'b1);

    // 256 decodes wrap the counter
    for (int i = 0; i < 256; i++) begin
      if (i == 255) chk("wrap_acc255", acc_cnt, 8'd255);
      in_valid = 1'b1; idx = 3'(i % 8);
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
    end
    chk("wrap_acc0", acc_cnt, 8'd0);
    chk("wrap_rdy", in_ready, 1'b1);

    // decode shape for idx=2, priority encoder must return 2
`ifdef PE_DECODER_THERMO_EN
    exp_thermo = 8'h07;
`else
    exp_thermo = 8'h04;
`endif
    in_valid = 1'b1; idx = 3'd2;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("th_q", q, exp_thermo);
      chk("th_penc", penc(q), 2);
      tick();
    end
    chk("th_end_q", q, 8'h00);
    chk("th_acc", acc_cnt, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
